// File: rtl/huffman_pkg.sv
// Shared constants, FSM state type and the fixed prefix-free code table used by
// the Huffman encoder (and its matching decoder table).
package huffman_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SYM_W   = 4;
    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned ACC_W   = WORD_W + MAX_LEN;
    localparam int unsigned CNT_W   = 6;

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDrain} huff_state_e;

    // Returns {code, len}; code is right-aligned, its first bit at code[len-1].
    function automatic logic [MAX_LEN+LEN_W-1:0] huff_lookup(input logic [SYM_W-1:0] sym);
        logic [MAX_LEN+LEN_W-1:0] r_ent;
        case (sym)
            4'd0:    r_ent = {8'h00, 4'd1};
            4'd1:    r_ent = {8'h02, 4'd2};
            4'd2:    r_ent = {8'h06, 4'd3};
            4'd3:    r_ent = {8'h0E, 4'd4};
            default: r_ent = {4'hF, sym, 4'd8};
        endcase
        return r_ent;
    endfunction

endpackage

// File: rtl/huffman_encoder_packer_if.sv
// Symbol-in / packed-word-out bus of the Huffman encoder.
// HUFF_ENC_STATS_EN adds the sym_count and word_count statistics outputs.
interface huffman_encoder_packer_if;
    import huffman_pkg::*;

    logic [SYM_W-1:0]  in;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [5:0]        out_nbits;
    logic              flush_done;
`ifdef HUFF_ENC_STATS_EN
    logic [15:0]       sym_count;
    logic [15:0]       word_count;
`endif

    modport master (
        output in, in_valid, flush, out_ready,
        input  in_ready, out_word, out_valid, out_last, out_nbits, flush_done
`ifdef HUFF_ENC_STATS_EN
        , input sym_count, word_count
`endif
    );

    modport slave (
        input  in, in_valid, flush, out_ready,
        output in_ready, out_word, out_valid, out_last, out_nbits, flush_done
`ifdef HUFF_ENC_STATS_EN
        , output sym_count, word_count
`endif
    );

endinterface

// File: rtl/huffman_code_lut.sv
// Combinational symbol -> Huffman code/length lookup.
module huffman_code_lut
    import huffman_pkg::*;
(
    input  logic [SYM_W-1:0]   i_sym,
    output logic [MAX_LEN-1:0] o_code,
    output logic [LEN_W-1:0]   o_len
);

    assign {o_code, o_len} = huff_lookup(i_sym);

endmodule

// File: rtl/huffman_encoder_packer.sv
// Huffman encoder: maps symbols to codes and packs them MSB-first into 32-bit words.
// Define HUFF_ENC_STATS_EN to add accepted-symbol and transferred-word counters.
module huffman_encoder_packer
    import huffman_pkg::*;
(
    input  logic clk,
    input  logic rst,
    huffman_encoder_packer_if.slave bus
);

    localparam logic [CNT_W-1:0] WordCnt = CNT_W'(WORD_W);

    huff_state_e        r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic               r_out_last;
    logic [5:0]         r_out_nbits;
    logic               r_flush_done;

    logic [MAX_LEN-1:0] w_code;
    logic [LEN_W-1:0]   w_len;
    logic [ACC_W-1:0]   w_acc_sh, w_acc_nx, w_ins;
    logic [CNT_W-1:0]   w_cnt_sh, w_cnt_nx, w_shamt;
    logic               w_in_ready, w_accept, w_xfer, w_full_nx;

    huffman_code_lut u_lut (
        .i_sym  (bus.in),
        .o_code (w_code),
        .o_len  (w_len)
    );

    assign w_in_ready = (r_state != StFlush) && (r_state != StDrain) && (r_cnt <= WordCnt);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_xfer     = r_out_valid && bus.out_ready;

    // A transfer shifts first; an accepted code lands right after the surviving bits.
    always_comb begin
        w_acc_sh = r_acc;
        w_cnt_sh = r_cnt;
        if (w_xfer) begin
            w_acc_sh = r_acc << WORD_W;
            w_cnt_sh = (r_state == StDrain) ? '0 : r_cnt - WordCnt;
        end
        w_shamt  = CNT_W'(ACC_W) - w_cnt_sh - CNT_W'(w_len);
        w_ins    = ACC_W'(w_code) << w_shamt;
        w_acc_nx = w_acc_sh;
        w_cnt_nx = w_cnt_sh;
        if (w_accept) begin
            w_acc_nx = w_acc_sh | w_ins;
            w_cnt_nx = w_cnt_sh + CNT_W'(w_len);
        end
    end

    assign w_full_nx = (w_cnt_nx >= WordCnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_nbits  <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_acc        <= w_acc_nx;
            r_cnt        <= w_cnt_nx;
            r_out_valid  <= w_full_nx;
            r_out_last   <= 1'b0;
            r_out_nbits  <= w_full_nx ? 6'(WORD_W) : 6'd0;
            r_flush_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state <= bus.flush ? StFlush : StRun;
                    end else if (bus.flush) begin
                        r_flush_done <= 1'b1;
                    end
                end
                StRun: begin
                    if (bus.flush) r_state <= StFlush;
                end
                StFlush: begin
                    if (r_cnt == '0) begin
                        r_state      <= StIdle;
                        r_flush_done <= 1'b1;
                    end else if (r_cnt < WordCnt) begin
                        r_state     <= StDrain;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                        r_out_nbits <= r_cnt;
                    end
                end
                StDrain: begin
                    if (w_xfer) begin
                        r_state      <= StIdle;
                        r_flush_done <= 1'b1;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                        r_out_nbits <= r_cnt;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_word   = r_acc[ACC_W-1 -: WORD_W];
    assign bus.out_valid  = r_out_valid;
    assign bus.out_last   = r_out_last;
    assign bus.out_nbits  = r_out_nbits;
    assign bus.flush_done = r_flush_done;

`ifdef HUFF_ENC_STATS_EN
    logic [15:0] r_sym_count;
    logic [15:0] r_word_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sym_count  <= '0;
            r_word_count <= '0;
        end else begin
            if (w_accept) r_sym_count <= r_sym_count + 16'd1;
            if (w_xfer)   r_word_count <= r_word_count + 16'd1;
        end
    end

    assign bus.sym_count  = r_sym_count;
    assign bus.word_count = r_word_count;
`endif

endmodule
